// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the round-robin adder arbiter.
// Optional flag outputs are enabled with the ADDER_ARB_FLAGS_EN macro.
package adder_arb_pkg;
   localparam int WIDTH_C = 64;
   localparam int NREQ_C  = 4;
   localparam int ID_W_C  = $clog2(NREQ_C);

   typedef logic [WIDTH_C-1:0] word_t;
   typedef logic [ID_W_C-1:0]  req_id_t;

   typedef struct packed {
      req_id_t id;
      word_t   sum;
      logic    cout;
   } rsp_t;

   // Signed overflow: operands agree in sign but the result does not.
   function automatic logic signed_ovf(input word_t a, input word_t b, input word_t s);
      return (a[WIDTH_C-1] == b[WIDTH_C-1]) && (s[WIDTH_C-1] != a[WIDTH_C-1]);
   endfunction
endpackage

// File: rtl/fullAdder64.sv
// 64-bit ripple-carry adder shared by all arbiter clients.
module fullAdder64 (
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        cin,
   output logic [63:0] sum,
   output logic        cout
);
   logic carry;

   // Carry is a procedural temporary so the chain is one combinational walk.
   always_comb begin
      carry = cin;
      sum   = '0;
      for (int i = 0; i < 64; i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cout = carry;
   end
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int N    = 4,
   parameter int ID_W = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [N-1:0]    gnt,
   output logic [ID_W-1:0] gnt_id,
   output logic            any
);
   logic [ID_W:0]   pos;
   logic [ID_W-1:0] idx;

   // Scan offsets from farthest to nearest so the nearest hit overwrites.
   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      any    = 1'b0;
      pos    = '0;
      idx    = '0;
      for (int k = N - 1; k >= 0; k--) begin
         pos = {1'b0, ptr} + (ID_W + 1)'(k);
         if (pos >= (ID_W + 1)'(N)) begin
            pos = pos - (ID_W + 1)'(N);
         end
         idx = pos[ID_W-1:0];
         if (req[idx]) begin
            gnt      = '0;
            gnt[idx] = 1'b1;
            gnt_id   = idx;
            any      = 1'b1;
         end
      end
   end
endmodule

// File: rtl/adder_rr_arbiter.sv
// Shares one fullAdder64 among NREQ requesters in round-robin order with a
// single-entry valid/ready result register. ADDER_ARB_FLAGS_EN adds rsp_ovf/rsp_zero.
module adder_rr_arbiter
   import adder_arb_pkg::*;
#(
   parameter  int NREQ  = NREQ_C,
   parameter  int WIDTH = WIDTH_C,
   localparam int ID_W  = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ-1:0]    req_cin,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [ID_W-1:0]    rsp_id,
   output logic [WIDTH-1:0]   rsp_sum,
   output logic               rsp_cout
`ifdef ADDER_ARB_FLAGS_EN
   ,
   output logic               rsp_ovf,
   output logic               rsp_zero
`endif
);
   logic            rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0] rsp_id_q, rsp_id_d;
   word_t           rsp_sum_q, rsp_sum_d;
   logic            rsp_cout_q, rsp_cout_d;
   logic [ID_W-1:0] ptr_q, ptr_d;

   logic [NREQ-1:0] gnt;
   logic [ID_W-1:0] gnt_id;
   logic            any;
   logic            accept;
   logic            xfer;

   word_t a_arr [NREQ];
   word_t b_arr [NREQ];
   word_t op_a, op_b, add_sum;
   logic  op_cin, add_cout;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
   end

   rr_arbiter #(.N(NREQ), .ID_W(ID_W)) u_rr (
      .req    (req_valid),
      .ptr    (ptr_q),
      .gnt    (gnt),
      .gnt_id (gnt_id),
      .any    (any)
   );

   assign op_a   = a_arr[gnt_id];
   assign op_b   = b_arr[gnt_id];
   assign op_cin = req_cin[gnt_id];

   fullAdder64 u_add (
      .a    (op_a),
      .b    (op_b),
      .cin  (op_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Gating with reset_n keeps req_ready low for the whole reset assertion.
   assign accept    = ~rsp_valid_q | rsp_ready;
   assign xfer      = reset_n & accept & any;
   assign req_ready = xfer ? gnt : '0;

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_sum_d   = rsp_sum_q;
      rsp_cout_d  = rsp_cout_q;
      ptr_d       = ptr_q;
      if (xfer) begin
         rsp_valid_d = 1'b1;
         rsp_id_d    = gnt_id;
         rsp_sum_d   = add_sum;
         rsp_cout_d  = add_cout;
         ptr_d       = (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + ID_W'(1);
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_sum_q   <= '0;
         rsp_cout_q  <= 1'b0;
         ptr_q       <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_sum_q   <= rsp_sum_d;
         rsp_cout_q  <= rsp_cout_d;
         ptr_q       <= ptr_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_cout  = rsp_cout_q;

`ifdef ADDER_ARB_FLAGS_EN
   logic ovf_q, ovf_d, zero_q, zero_d;

   always_comb begin
      ovf_d  = ovf_q;
      zero_d = zero_q;
      if (xfer) begin
         ovf_d  = signed_ovf(op_a, op_b, add_sum);
         zero_d = (add_sum == '0);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

   assign rsp_ovf  = ovf_q;
   assign rsp_zero = zero_q;
`endif
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed, table-driven bench for adder_rr_arbiter (NREQ=4), plus hand-written
// back-pressure and async-reset sequences. Flag checks follow ADDER_ARB_FLAGS_EN.
module tb_adder_rr_arbiter;
   import adder_arb_pkg::*;

   localparam int NR = 4;
   localparam int NV = 15;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [NR-1:0]   req_valid;
   logic [NR-1:0]   req_ready;
   logic [NR*64-1:0] req_a;
   logic [NR*64-1:0] req_b;
   logic [NR-1:0]   req_cin;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [1:0]      rsp_id;
   logic [63:0]     rsp_sum;
   logic            rsp_cout;
`ifdef ADDER_ARB_FLAGS_EN
   logic            rsp_ovf;
   logic            rsp_zero;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] valid;
      logic       spread;
      word_t      a;
      word_t      b;
      logic       cin;
      logic       rdy;
      logic [3:0] exp_ready;
      logic       exp_valid;
      logic [1:0] exp_id;
      word_t      exp_sum;
      logic       exp_cout;
      logic       exp_ovf;
      logic       exp_zero;
   } vec_t;

   vec_t vecs [NV];
   vec_t bp;

   adder_rr_arbiter dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout)
`ifdef ADDER_ARB_FLAGS_EN
      ,
      .rsp_ovf   (rsp_ovf),
      .rsp_zero  (rsp_zero)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Valid slices carry the vector operands (offset by index when spread);
   // idle slices carry junk so a wrong operand select shows up in the sum.
   task automatic apply(input vec_t v);
      req_valid = v.valid;
      rsp_ready = v.rdy;
      for (int i = 0; i < NR; i++) begin
         if (v.valid[i]) begin
            req_a[i*64 +: 64] = v.a + (v.spread ? (64'(i) << 16) : 64'd0);
            req_b[i*64 +: 64] = v.b;
            req_cin[i]        = v.cin;
         end else begin
            req_a[i*64 +: 64] = 64'hDEAD_BEEF_0000_0000 | 64'(i);
            req_b[i*64 +: 64] = 64'h0BAD_F00D_0000_0000;
            req_cin[i]        = 1'b1;
         end
      end
   endtask

   task automatic check_rsp(input logic ev, input logic [1:0] id, input word_t sum,
                            input logic cout, input logic ovf, input logic zero);
      chk("rsp_valid", 64'(rsp_valid), 64'(ev));
      if (ev) begin
         chk("rsp_id", 64'(rsp_id), 64'(id));
         chk("rsp_sum", rsp_sum, sum);
         chk("rsp_cout", 64'(rsp_cout), 64'(cout));
`ifdef ADDER_ARB_FLAGS_EN
         chk("rsp_ovf", 64'(rsp_ovf), 64'(ovf));
         chk("rsp_zero", 64'(rsp_zero), 64'(zero));
`else
         if (ovf && zero && !ev) $display("unreachable");
`endif
      end
   endtask

   task automatic run_vec(input vec_t v, input int n);
      apply(v);
      @(negedge clk);
      chk("req_ready", 64'(req_ready), 64'(v.exp_ready));
      @(posedge clk);
      #1;
      check_rsp(v.exp_valid, v.exp_id, v.exp_sum, v.exp_cout, v.exp_ovf, v.exp_zero);
      $display("vec %0d: valid=%b ready=%b -> rsp_valid=%0d id=%0d sum=%h cout=%0d",
               n, v.valid, req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Round-robin over all four requesters: sum = 0x30 + (id << 16).
      for (int k = 0; k < 8; k++) begin
         vecs[k] = '{4'b1111, 1'b1, 64'h10, 64'h20, 1'b0, 1'b1,
                     4'(1 << (k % 4)), 1'b1, 2'(k % 4), 64'h30 + (64'(k % 4) << 16),
                     1'b0, 1'b0, 1'b0};
      end
      vecs[8]  = '{4'b0100, 1'b0, 64'd5, 64'd7, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2,
                   64'd13, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{4'b0010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 4'b0010,
                   1'b1, 2'd1, 64'd0, 1'b1, 1'b0, 1'b1};
      vecs[10] = '{4'b1000, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 4'b1000,
                   1'b1, 2'd3, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
      vecs[11] = '{4'b0001, 1'b0, 64'd10, ~64'd3, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0,
                   64'd7, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{4'b0001, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                   1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, 64'd0, 1'b1, 1'b1, 1'b1};
      vecs[13] = '{4'b0000, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0,
                   64'd0, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{4'b1110, 1'b1, 64'd0, 64'd0, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1,
                   64'h1_0001, 1'b0, 1'b0, 1'b0};
      bp       = '{4'b1111, 1'b1, 64'd0, 64'h100, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1,
                   64'h1_0001, 1'b0, 1'b0, 1'b0};

      // Reset with every request pending.
      reset_n   = 1'b0;
      req_valid = '1;
      rsp_ready = 1'b0;
      req_a     = '0;
      req_b     = '0;
      req_cin   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset req_ready", 64'(req_ready), 64'd0);
      chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset rsp_sum", rsp_sum, 64'd0);
      chk("reset rsp_id", 64'(rsp_id), 64'd0);
      reset_n = 1'b1;
      #1;
      chk("post-reset grant", 64'(req_ready), 64'b0001);

      for (int k = 0; k < NV; k++) begin
         run_vec(vecs[k], k);
      end

      // Back-pressure: result id1 held for three cycles, pointer sits at 2.
      apply(bp);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("stall req_ready", 64'(req_ready), 64'd0);
         @(posedge clk);
         #1;
         check_rsp(1'b1, 2'd1, 64'h1_0001, 1'b0, 1'b0, 1'b0);
         $display("stall %0d: rsp_valid=%0d id=%0d sum=%h", c, rsp_valid, rsp_id, rsp_sum);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("release req_ready", 64'(req_ready), 64'b0100);
      @(posedge clk);
      #1;
      check_rsp(1'b1, 2'd2, 64'h2_0100, 1'b0, 1'b0, 1'b0);
      $display("release: rsp_valid=%0d id=%0d sum=%h", rsp_valid, rsp_id, rsp_sum);

      // Async reset while stalled: result dropped at once, pointer back to 0.
      rsp_ready = 1'b0;
      @(negedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("midreset rsp_valid", 64'(rsp_valid), 64'd0);
      chk("midreset rsp_sum", rsp_sum, 64'd0);
      chk("midreset req_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      #1;
      chk("midreset ptr grant", 64'(req_ready), 64'b0001);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      check_rsp(1'b1, 2'd0, 64'h100, 1'b0, 1'b0, 1'b0);
      $display("after reset: rsp_valid=%0d id=%0d sum=%h", rsp_valid, rsp_id, rsp_sum);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
